// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational instruction memory
// and buffers {pc, instr} pairs in a small FIFO drained by decode via valid/ready.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic [31:0]                imem_addr_o,
  input  logic [31:0]                imem_instr_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_o,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     pc_mem_q    [DEPTH];

  logic pop;
  logic enq;

  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o & instr_ready_i;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign enq           = ~redirect_i & ((count_q < CntW'(DEPTH)) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      // Flush wins over any same-cycle pop; low address bits are dropped.
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (enq) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(enq) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enq) begin
      instr_mem_q[wr_ptr_q] <= imem_instr_i;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign instr_o     = instr_valid_o ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign pc_o        = instr_valid_o ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign count_o     = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; memory model returns 0x100 + word index.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  int vecs = 0;
  int errs = 0;

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .count_o       (count)
  );

  assign imem_instr = 32'h100 + (imem_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    rst         = 1'b1;
    step();
    step();
    vecs++;
    if ({instr_valid, count, imem_addr, instr, pc} !== {1'b0, 3'd0, 32'h0, 32'h0, 32'h0}) begin
      $display("FAIL reset_state: valid=%0b count=%0d addr=%h instr=%h pc=%h, need all zero",
               instr_valid, count, imem_addr, instr, pc);
      errs++;
    end
    rst = 1'b0;
    step();
    vecs++;
    if ({instr_valid, count, imem_addr, instr, pc} !==
        {1'b1, 3'd1, 32'h4, 32'h100, 32'h0}) begin
      $display("FAIL reset_release: valid=%0b count=%0d addr=%h instr=%h pc=%h, need 1 1 4 100 0",
               instr_valid, count, imem_addr, instr, pc);
      errs++;
    end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      vecs++;
      if ({instr_valid, pc, instr, count} !==
          {1'b1, 32'(4 * (k - 1)), 32'(32'h100 + k - 1), 3'd1}) begin
        $display("FAIL stream_%0d: valid=%0b pc=%h instr=%h count=%0d, need 1 %h %h 1", k,
                 instr_valid, pc, instr, count, 4 * (k - 1), 32'h100 + k - 1);
        errs++;
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_cnt;
    instr_ready = 1'b0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_cnt = (k < 4) ? k : 4;
      vecs++;
      if ({count, imem_addr, pc, instr} !==
          {3'(exp_cnt), 32'(4 * exp_cnt), 32'h0, 32'h100}) begin
        $display("FAIL fill_%0d: count=%0d addr=%h pc=%h instr=%h, need %0d %h 0 100", k,
                 count, imem_addr, pc, instr, exp_cnt, 4 * exp_cnt);
        errs++;
      end
    end
    // Full FIFO drained with ready held: pop and enqueue each cycle, no bubble.
    instr_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      vecs++;
      if ({instr_valid, pc, count, imem_addr} !==
          {1'b1, 32'(4 * j), 3'd4, 32'(16 + 4 * j)}) begin
        $display("FAIL drain_%0d: valid=%0b pc=%h count=%0d addr=%h, need 1 %h 4 %h", j,
                 instr_valid, pc, count, imem_addr, 4 * j, 16 + 4 * j);
        errs++;
      end
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    vecs++;
    if (count !== 3'd3) begin
      $display("FAIL redir_prefill: count=%0d, need 3", count);
      errs++;
    end
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    vecs++;
    if ({instr_valid, count, imem_addr} !== {1'b0, 3'd0, 32'h40}) begin
      $display("FAIL redir_flush: valid=%0b count=%0d addr=%h, need 0 0 40",
               instr_valid, count, imem_addr);
      errs++;
    end
    step();
    vecs++;
    if ({instr_valid, pc, instr, count, imem_addr} !==
        {1'b1, 32'h40, 32'h110, 3'd1, 32'h44}) begin
      $display("FAIL redir_head: valid=%0b pc=%h instr=%h count=%0d addr=%h, need 1 40 110 1 44",
               instr_valid, pc, instr, count, imem_addr);
      errs++;
    end
  endtask

  task automatic test_redirect_pop();
    // Continues from test_redirect: one entry at the head, popped during the redirect.
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    step();
    redirect = 1'b0;
    vecs++;
    if ({instr_valid, count, imem_addr} !== {1'b0, 3'd0, 32'h40}) begin
      $display("FAIL redir_pop: valid=%0b count=%0d addr=%h, need 0 0 40",
               instr_valid, count, imem_addr);
      errs++;
    end
    step();
    vecs++;
    if ({pc, instr} !== {32'h40, 32'h110}) begin
      $display("FAIL redir_align: pc=%h instr=%h, need 40 110", pc, instr);
      errs++;
    end
    // Back-to-back redirects: the second target wins.
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    vecs++;
    if ({count, imem_addr} !== {3'd0, 32'h200}) begin
      $display("FAIL redir_b2b: count=%0d addr=%h, need 0 200", count, imem_addr);
      errs++;
    end
    step();
    vecs++;
    if ({instr_valid, pc, instr} !== {1'b1, 32'h200, 32'h180}) begin
      $display("FAIL redir_b2b_head: valid=%0b pc=%h instr=%h, need 1 200 180",
               instr_valid, pc, instr);
      errs++;
    end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    step();
    step();
    vecs++;
    if ({count, imem_addr, pc, instr} !== {3'd2, 32'h0, 32'hFFFF_FFF8, 32'h4000_00FE}) begin
      $display("FAIL wrap_addr: count=%0d addr=%h pc=%h instr=%h, need 2 0 fffffff8 400000fe",
               count, imem_addr, pc, instr);
      errs++;
    end
    instr_ready = 1'b1;
    step();
    vecs++;
    if ({pc, instr} !== {32'hFFFF_FFFC, 32'h4000_00FF}) begin
      $display("FAIL wrap_pop1: pc=%h instr=%h, need fffffffc 400000ff", pc, instr);
      errs++;
    end
    step();
    vecs++;
    if ({pc, instr} !== {32'h0, 32'h100}) begin
      $display("FAIL wrap_pop2: pc=%h instr=%h, need 0 100", pc, instr);
      errs++;
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    vecs++;
    if (count !== 3'd4) begin
      $display("FAIL midrst_full: count=%0d, need 4", count);
      errs++;
    end
    instr_ready = 1'b1;
    rst         = 1'b1;
    step();
    rst = 1'b0;
    vecs++;
    if ({instr_valid, count, imem_addr, instr, pc} !== {1'b0, 3'd0, 32'h0, 32'h0, 32'h0}) begin
      $display("FAIL midrst: valid=%0b count=%0d addr=%h instr=%h pc=%h, need all zero",
               instr_valid, count, imem_addr, instr, pc);
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
